// File: rtl/cmd_response_receiver.sv
// rtl/cmd_response_receiver.sv - SD host CMD-line response receiver
// Hunts for a start bit with NCR timeout, captures a 48-bit frame MSB-first, checks CRC7/framing.
module cmd_response_receiver #(
  parameter int RESP_BITS = 48,
  parameter int TIMEOUT   = 64
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 crc_check_en,
  input  logic                 cmd_in,
  output logic [RESP_BITS-1:0] response,
  output logic                 done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 crc_err,
  output logic                 frame_err
);

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, FINISH} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [5:0] BIT_LAST  = 6'(RESP_BITS - 1);
  localparam logic [5:0] CRC_BITS  = 6'(RESP_BITS - 8);

  state_t                 state, state_nxt;
  logic [7:0]             wait_cnt;
  logic [5:0]             bit_cnt;
  logic [RESP_BITS-1:0]   shift_reg;
  logic [6:0]             crc;
  logic                   crc_en_q;
  logic                   timeout_q;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
    logic fb;
    fb = d ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = WAIT_START;
      WAIT_START: begin
        if (!cmd_in)                    state_nxt = RECEIVE;
        else if (wait_cnt == WAIT_LAST) state_nxt = FINISH;
      end
      RECEIVE:    if (bit_cnt == BIT_LAST) state_nxt = FINISH;
      FINISH:     state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // FINISH is a one-cycle settle so done and the results land together as busy falls
  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      response    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      crc         <= '0;
      crc_en_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            timeout_err <= 1'b0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            wait_cnt    <= '0;
            crc         <= '0;
            crc_en_q    <= crc_check_en;
            timeout_q   <= 1'b0;
          end
        end
        WAIT_START: begin
          if (!cmd_in) begin
            shift_reg <= {shift_reg[RESP_BITS-2:0], cmd_in};
            bit_cnt   <= 6'd1;
            crc       <= crc7_step(7'd0, cmd_in);
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RECEIVE: begin
          shift_reg <= {shift_reg[RESP_BITS-2:0], cmd_in};
          bit_cnt   <= bit_cnt + 6'd1;
          if (bit_cnt < CRC_BITS) crc <= crc7_step(crc, cmd_in);
        end
        FINISH: begin
          if (timeout_q) begin
            timeout_err <= 1'b1;
          end else begin
            response  <= shift_reg;
            crc_err   <= crc_en_q && (shift_reg[7:1] != crc);
            frame_err <= shift_reg[RESP_BITS-2] | ~shift_reg[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
